// File: rtl/hsi_pkg.sv
// Shared types and constants for the HSI colour-mask stage.
// Stats logic is built only when HSI_BBOX_STATS_EN is defined.
package hsi_pkg;

  localparam int HSI_W   = 8;
  localparam int COORD_W = 10;
  localparam int CNT_W   = 19;
  localparam int H_DISP  = 640;
  localparam int V_DISP  = 480;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  typedef struct packed {
    logic [HSI_W-1:0] h_lo;
    logic [HSI_W-1:0] h_hi;
    logic [HSI_W-1:0] s_lo;
    logic [HSI_W-1:0] i_lo;
  } thr_t;

  localparam logic [COORD_W-1:0] MIN_RST = '1;
  localparam logic [COORD_W-1:0] MAX_RST = '0;
  localparam logic [CNT_W-1:0]   CNT_RST = '0;
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;
  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(H_DISP - 1);
  localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(V_DISP - 1);

endpackage

// File: rtl/hsi_range_cmp.sv
// Combinational HSI threshold test; hue range may wrap through red.
module hsi_range_cmp
  import hsi_pkg::*;
(
  input  thr_t             thr,
  input  logic [HSI_W-1:0] h,
  input  logic [HSI_W-1:0] s,
  input  logic [HSI_W-1:0] i,
  output logic             match
);

  logic hue_ok;

  always_comb begin
    hue_ok = 1'b0;
    if (thr.h_lo <= thr.h_hi)
      hue_ok = (h >= thr.h_lo) && (h <= thr.h_hi);
    else
      hue_ok = (h >= thr.h_lo) || (h <= thr.h_hi);
    match = hue_ok && (s >= thr.s_lo) && (i >= thr.i_lo);
  end

endmodule

// File: rtl/hsi_color_mask.sv
// Two-stage HSI colour mask with per-frame bounding-box statistics.
// Stats logic is built only when HSI_BBOX_STATS_EN is defined.
module hsi_color_mask
  import hsi_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               HSI_hsync,
  input  logic               HSI_vsync,
  input  logic               HSI_de,
  input  logic [HSI_W-1:0]   H_data,
  input  logic [HSI_W-1:0]   S_data,
  input  logic [HSI_W-1:0]   I_data,
  input  logic [HSI_W-1:0]   h_lo,
  input  logic [HSI_W-1:0]   h_hi,
  input  logic [HSI_W-1:0]   s_lo,
  input  logic [HSI_W-1:0]   i_lo,
  output logic               mask_hsync,
  output logic               mask_vsync,
  output logic               mask_de,
  output logic               mask_data,
  output logic [COORD_W-1:0] bbox_x_min,
  output logic [COORD_W-1:0] bbox_x_max,
  output logic [COORD_W-1:0] bbox_y_min,
  output logic [COORD_W-1:0] bbox_y_max,
  output logic [CNT_W-1:0]   pix_count,
  output logic               bbox_empty,
  output logic               bbox_valid
);

  thr_t thr_in, thr_q, thr_eff;
  logic vs_q, fs, match;
  logic s1_hs, s1_vs, s1_de, s1_match;

  assign thr_in  = {h_lo, h_hi, s_lo, i_lo};
  assign fs      = HSI_vsync & ~vs_q;
  // frame-start pixel already uses the new thresholds
  assign thr_eff = fs ? thr_in : thr_q;

  hsi_range_cmp u_cmp (
    .thr   (thr_eff),
    .h     (H_data),
    .s     (S_data),
    .i     (I_data),
    .match (match)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q       <= 1'b0;
      thr_q      <= '0;
      s1_hs      <= 1'b0;
      s1_vs      <= 1'b0;
      s1_de      <= 1'b0;
      s1_match   <= 1'b0;
      mask_hsync <= 1'b0;
      mask_vsync <= 1'b0;
      mask_de    <= 1'b0;
      mask_data  <= 1'b0;
    end else begin
      vs_q       <= HSI_vsync;
      if (fs) thr_q <= thr_in;
      s1_hs      <= HSI_hsync;
      s1_vs      <= HSI_vsync;
      s1_de      <= HSI_de;
      s1_match   <= match & HSI_de;
      mask_hsync <= s1_hs;
      mask_vsync <= s1_vs;
      mask_de    <= s1_de;
      mask_data  <= s1_match & s1_de;
    end
  end

`ifdef HSI_BBOX_STATS_EN

  state_t state_q, state_d;
  logic acc_en, rpt_en, de_q, hit;
  logic [COORD_W-1:0] x_cnt, y_cnt, cur_x, cur_y;
  logic [COORD_W-1:0] ax_min, ax_max, ay_min, ay_max;
  logic [COORD_W-1:0] nx_min, nx_max, ny_min, ny_max;
  logic [CNT_W-1:0]   a_cnt, n_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fs) state_d = ACTIVE;
      ACTIVE:  state_d = ACTIVE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_en = 1'b0;
    rpt_en = 1'b0;
    unique case (state_q)
      IDLE:    acc_en = fs;
      ACTIVE: begin
        acc_en = 1'b1;
        rpt_en = fs;
      end
      default: ;
    endcase
  end

  assign cur_x = fs ? '0 : x_cnt;
  assign cur_y = fs ? '0 : y_cnt;
  assign hit   = HSI_de & match;

  always_comb begin
    nx_min = fs ? MIN_RST : ax_min;
    nx_max = fs ? MAX_RST : ax_max;
    ny_min = fs ? MIN_RST : ay_min;
    ny_max = fs ? MAX_RST : ay_max;
    n_cnt  = fs ? CNT_RST : a_cnt;
    if (acc_en && hit) begin
      if (cur_x < nx_min) nx_min = cur_x;
      if (cur_x > nx_max) nx_max = cur_x;
      if (cur_y < ny_min) ny_min = cur_y;
      if (cur_y > ny_max) ny_max = cur_y;
      if (n_cnt != CNT_MAX) n_cnt = n_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q  <= 1'b0;
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      de_q <= HSI_de;
      if (fs) begin
        x_cnt <= HSI_de ? COORD_W'(1) : '0;
        y_cnt <= '0;
      end else if (HSI_de) begin
        if (x_cnt != X_LAST) x_cnt <= x_cnt + 1'b1;
      end else if (de_q) begin
        x_cnt <= '0;
        if (y_cnt != Y_LAST) y_cnt <= y_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ax_min     <= MIN_RST;
      ax_max     <= MAX_RST;
      ay_min     <= MIN_RST;
      ay_max     <= MAX_RST;
      a_cnt      <= CNT_RST;
      bbox_x_min <= '0;
      bbox_x_max <= '0;
      bbox_y_min <= '0;
      bbox_y_max <= '0;
      pix_count  <= '0;
      bbox_empty <= 1'b1;
      bbox_valid <= 1'b0;
    end else begin
      ax_min     <= nx_min;
      ax_max     <= nx_max;
      ay_min     <= ny_min;
      ay_max     <= ny_max;
      a_cnt      <= n_cnt;
      bbox_valid <= rpt_en;
      if (rpt_en) begin
        pix_count  <= a_cnt;
        bbox_empty <= (a_cnt == CNT_RST);
        if (a_cnt == CNT_RST) begin
          bbox_x_min <= '0;
          bbox_x_max <= '0;
          bbox_y_min <= '0;
          bbox_y_max <= '0;
        end else begin
          bbox_x_min <= ax_min;
          bbox_x_max <= ax_max;
          bbox_y_min <= ay_min;
          bbox_y_max <= ay_max;
        end
      end
    end
  end

`else

  assign bbox_x_min = '0;
  assign bbox_x_max = '0;
  assign bbox_y_min = '0;
  assign bbox_y_max = '0;
  assign pix_count  = '0;
  assign bbox_empty = 1'b1;
  assign bbox_valid = 1'b0;

`endif

endmodule

// File: tb/tb_hsi_color_mask.sv
// Directed bench for hsi_color_mask with a per-cycle output scoreboard.
// Bbox expectations follow HSI_BBOX_STATS_EN.
module tb_hsi_color_mask;

`ifdef HSI_BBOX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       HSI_hsync, HSI_vsync, HSI_de;
  logic [7:0] H_data, S_data, I_data;
  logic [7:0] h_lo, h_hi, s_lo, i_lo;
  logic       mask_hsync, mask_vsync, mask_de, mask_data;
  logic [9:0] bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max;
  logic [18:0] pix_count;
  logic       bbox_empty, bbox_valid;

  hsi_color_mask dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .HSI_hsync  (HSI_hsync),
    .HSI_vsync  (HSI_vsync),
    .HSI_de     (HSI_de),
    .H_data     (H_data),
    .S_data     (S_data),
    .I_data     (I_data),
    .h_lo       (h_lo),
    .h_hi       (h_hi),
    .s_lo       (s_lo),
    .i_lo       (i_lo),
    .mask_hsync (mask_hsync),
    .mask_vsync (mask_vsync),
    .mask_de    (mask_de),
    .mask_data  (mask_data),
    .bbox_x_min (bbox_x_min),
    .bbox_x_max (bbox_x_max),
    .bbox_y_min (bbox_y_min),
    .bbox_y_max (bbox_y_max),
    .pix_count  (pix_count),
    .bbox_empty (bbox_empty),
    .bbox_valid (bbox_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic m;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [7:0] m_hlo, m_hhi, m_slo, m_ilo;
  logic m_prev_vs;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic model_match(input logic [7:0] h,
                                       input logic [7:0] s,
                                       input logic [7:0] i);
    logic hue;
    if (m_hlo <= m_hhi) hue = (h >= m_hlo) && (h <= m_hhi);
    else                hue = (h >= m_hlo) || (h <= m_hhi);
    return hue && (s >= m_slo) && (i >= m_ilo);
  endfunction

  task automatic cyc();
    exp_t e;
    if (HSI_vsync && !m_prev_vs) begin
      m_hlo = h_lo;
      m_hhi = h_hi;
      m_slo = s_lo;
      m_ilo = i_lo;
    end
    m_prev_vs = HSI_vsync;
    e.hs = HSI_hsync;
    e.vs = HSI_vsync;
    e.de = HSI_de;
    e.m  = HSI_de && model_match(H_data, S_data, I_data);
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() >= 2) begin
      e = q.pop_front();
      chk("mask_out", {mask_hsync, mask_vsync, mask_de, mask_data}, e);
    end
  endtask

  task automatic pix(input logic [7:0] h, input logic [7:0] s,
                     input logic [7:0] i, input logic de);
    H_data = h;
    S_data = s;
    I_data = i;
    HSI_de = de;
    HSI_hsync = ~de;
    cyc();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) pix(8'd0, 8'd0, 8'd0, 1'b0);
  endtask

  task automatic line(input int len, input int m1, input int m2);
    for (int x = 0; x < len; x++)
      pix((x == m1 || x == m2) ? 8'd30 : 8'd100, 8'd50, 8'd50, 1'b1);
    idle(1);
  endtask

  task automatic frame_start(input string tag, input bit rpt);
    int pulses;
    logic first;
    pulses = 0;
    HSI_de = 1'b0;
    HSI_hsync = 1'b0;
    HSI_vsync = 1'b1;
    cyc();
    first = bbox_valid;
    pulses += int'(bbox_valid);
    cyc();
    pulses += int'(bbox_valid);
    HSI_vsync = 1'b0;
    cyc();
    pulses += int'(bbox_valid);
    cyc();
    pulses += int'(bbox_valid);
    chk({tag, "_valid_first"}, 64'(first), 64'(rpt & STATS));
    chk({tag, "_pulses"}, 64'(pulses), 64'(rpt & STATS));
  endtask

  task automatic chk_bbox(input string tag, input int xmn, input int xmx,
                          input int ymn, input int ymx, input int cnt);
    chk({tag, "_xmin"}, 64'(bbox_x_min), STATS ? 64'(xmn) : 64'd0);
    chk({tag, "_xmax"}, 64'(bbox_x_max), STATS ? 64'(xmx) : 64'd0);
    chk({tag, "_ymin"}, 64'(bbox_y_min), STATS ? 64'(ymn) : 64'd0);
    chk({tag, "_ymax"}, 64'(bbox_y_max), STATS ? 64'(ymx) : 64'd0);
    chk({tag, "_count"}, 64'(pix_count), STATS ? 64'(cnt) : 64'd0);
    chk({tag, "_empty"}, 64'(bbox_empty),
        (STATS && cnt != 0) ? 64'd0 : 64'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_mask"}, {mask_hsync, mask_vsync, mask_de, mask_data}, 0);
    chk({tag, "_bbox"}, {bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max,
                         pix_count}, 0);
    chk({tag, "_empty"}, 64'(bbox_empty), 64'd1);
    chk({tag, "_valid"}, 64'(bbox_valid), 64'd0);
  endtask

  task automatic model_reset();
    q.delete();
    m_hlo = '0;
    m_hhi = '0;
    m_slo = '0;
    m_ilo = '0;
    m_prev_vs = 1'b0;
  endtask

  task automatic set_thr(input logic [7:0] hl, input logic [7:0] hh);
    h_lo = hl;
    h_hi = hh;
    s_lo = 8'd10;
    i_lo = 8'd10;
  endtask

  initial begin
    rst_n = 1'b0;
    HSI_hsync = 1'b0;
    HSI_vsync = 1'b0;
    HSI_de = 1'b0;
    H_data = '0;
    S_data = '0;
    I_data = '0;
    set_thr(8'd20, 8'd40);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;

    // non-wrap thresholds, including range and S/I boundaries
    idle(2);
    frame_start("first_fs", 1'b0);
    pix(8'd30, 8'd50, 8'd50, 1'b1);
    pix(8'd41, 8'd50, 8'd50, 1'b1);
    pix(8'd20, 8'd10, 8'd10, 1'b1);
    pix(8'd40, 8'd50, 8'd50, 1'b1);
    pix(8'd30, 8'd9, 8'd50, 1'b1);
    pix(8'd30, 8'd50, 8'd9, 1'b1);
    pix(8'd19, 8'd50, 8'd50, 1'b1);
    idle(3);

    // wrap thresholds; report of previous frame: x 0..3, y 0, 3 hits
    set_thr(8'd240, 8'd10);
    frame_start("wrap_fs", 1'b1);
    chk_bbox("frame1", 0, 3, 0, 0, 3);
    pix(8'd250, 8'd50, 8'd50, 1'b1);
    pix(8'd5, 8'd50, 8'd50, 1'b1);
    pix(8'd100, 8'd50, 8'd50, 1'b1);
    pix(8'd240, 8'd50, 8'd50, 1'b1);
    pix(8'd10, 8'd50, 8'd50, 1'b1);
    pix(8'd11, 8'd50, 8'd50, 1'b1);
    pix(8'd239, 8'd50, 8'd50, 1'b1);
    idle(3);

    // bounding-box frame: hits only at (100,50) and (300,200)
    set_thr(8'd20, 8'd40);
    frame_start("bbox_open", 1'b1);
    for (int y = 0; y <= 200; y++)
      line((y == 50) ? 101 : (y == 200) ? 301 : 1,
           (y == 50) ? 100 : -1, (y == 200) ? 300 : -1);
    frame_start("bbox_fs", 1'b1);
    chk_bbox("bbox", 100, 300, 50, 200, 2);

    // empty frame
    for (int y = 0; y < 3; y++) line(5, -1, -1);
    frame_start("empty_fs", 1'b1);
    chk_bbox("empty", 0, 0, 0, 0, 0);

    // mid-frame threshold change is deferred to the next frame
    pix(8'd30, 8'd50, 8'd50, 1'b1);
    h_hi = 8'd25;
    pix(8'd30, 8'd50, 8'd50, 1'b1);
    pix(8'd26, 8'd50, 8'd50, 1'b1);
    idle(2);
    frame_start("thr_fs", 1'b1);
    pix(8'd30, 8'd50, 8'd50, 1'b1);
    pix(8'd22, 8'd50, 8'd50, 1'b1);
    pix(8'd26, 8'd50, 8'd50, 1'b1);
    idle(2);
    frame_start("thr_fs2", 1'b1);
    chk_bbox("thr_frame", 1, 1, 0, 0, 1);

    // reset mid-frame
    pix(8'd22, 8'd50, 8'd50, 1'b1);
    pix(8'd22, 8'd50, 8'd50, 1'b1);
    rst_n = 1'b0;
    #2;
    chk_reset("midrst");
    HSI_de = 1'b0;
    HSI_hsync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("midrst_hold");
    rst_n = 1'b1;
    model_reset();
    idle(2);
    frame_start("post_rst_fs1", 1'b0);
    pix(8'd22, 8'd50, 8'd50, 1'b1);
    idle(2);
    frame_start("post_rst_fs2", 1'b1);
    chk_bbox("post_rst", 0, 0, 0, 0, 1);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
